axil_stream_fifo: RTL and testbench

Parametrised AXI4-Lite to AXI4-Stream FIFO bridge. It replaces the vendor-IP FIFO wrapper with team-owned RTL and adds configurable TX/RX depths, packet-boundary (TLAST) control per word, error reporting, a soft flush and maskable interrupts. It sits between the processor AXI-Lite interconnect and the debug-stream fabric: words written by the CPU leave on the TX stream, and RX stream words are popped by CPU reads.

---
 rtl/axil_stream_fifo_if.sv | 57 +++++
 rtl/axil_stream_fifo.sv | 189 ++++++++++++++++++
 tb/tb_axil_stream_fifo.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_stream_fifo_if.sv
// AXI4-Lite slave bus plus the TX/RX AXI4-Stream pair of axil_stream_fifo.
//   slave  : the bridge (accepts AXI-Lite, drives TX stream, accepts RX stream)
//   master : CPU/interconnect + stream fabric side
// Signals: s_axi_aw*/w*/b*/ar*/r* (32-bit data, ADDR_W address),
//          axi_str_txd_t{valid,ready,last,data}, axi_str_rxd_t{valid,ready,last,data}
interface axil_stream_fifo_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  logic              axi_str_txd_tvalid;
  logic              axi_str_txd_tready;
  logic              axi_str_txd_tlast;
  logic [31:0]       axi_str_txd_tdata;
  logic              axi_str_rxd_tvalid;
  logic              axi_str_rxd_tready;
  logic              axi_str_rxd_tlast;
  logic [31:0]       axi_str_rxd_tdata;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output axi_str_txd_tvalid, axi_str_txd_tlast, axi_str_txd_tdata,
    input  axi_str_txd_tready,
    input  axi_str_rxd_tvalid, axi_str_rxd_tlast, axi_str_rxd_tdata,
    output axi_str_rxd_tready
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  axi_str_txd_tvalid, axi_str_txd_tlast, axi_str_txd_tdata,
    output axi_str_txd_tready,
    output axi_str_rxd_tvalid, axi_str_rxd_tlast, axi_str_rxd_tdata,
    input  axi_str_rxd_tready
  );
endinterface

// File: rtl/axil_stream_fifo.sv
// AXI4-Lite to AXI4-Stream FIFO bridge. CPU writes to TXD/TXD_LAST leave on the
// TX stream (first-word-fall-through); RX stream words are popped by RXD reads.
// Ports:
//   s_axi_aclk, s_axi_aresetn (async, active low)
//   bus                     : axil_stream_fifo_if.slave (AXI-Lite + both streams)
//   mm2s/s2mm_prmry_reset_out_n : low in reset and for the cycle after a flush
//   interrupt               : |(ISR & IER)
// Optional feature: define AXIL_FIFO_IRQ_EN to implement ISR/IER/interrupt;
// otherwise they read 0 and interrupt is tied low (SLVERR still generated).
module axil_stream_fifo #(
  parameter int TX_DEPTH = 512,
  parameter int RX_DEPTH = 512,
  parameter int ADDR_W   = 32
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  axil_stream_fifo_if.slave   bus,
  output logic                mm2s_prmry_reset_out_n,
  output logic                s2mm_prmry_reset_out_n,
  output logic                interrupt
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);
  localparam logic [1:0]   RESP_OKAY   = 2'b00;
  localparam logic [1:0]   RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_TXD, REG_TXD_LAST, REG_RXD, REG_STATUS,
    REG_RX_HEAD, REG_ISR, REG_IER, REG_CTRL
  } reg_e;

  logic [32:0]    tx_mem [TX_DEPTH];
  logic [32:0]    rx_mem [RX_DEPTH];
  logic [TXA-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RXA-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [TXA:0]   tx_count, tx_vac;
  logic [RXA:0]   rx_count;
  logic           run, flush_n;
  logic [2:0]     isr, ier, irq_ev;
  logic [31:0]    rd_mux;
  reg_e           wr_sel, rd_sel;
  logic           wr_go, rd_go, flush;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic           wr_txd, tx_push, tx_pop, tx_err;
  logic           rd_rxd, rx_push, rx_pop, rx_err;

  assign wr_sel = reg_e'(bus.s_axi_awaddr[4:2]);
  assign rd_sel = reg_e'(bus.s_axi_araddr[4:2]);

  // run gates every ready so all handshakes die with reset and restart one cycle later
  assign wr_go = run & bus.s_axi_awvalid & bus.s_axi_wvalid & ~bus.s_axi_bvalid;
  assign rd_go = run & bus.s_axi_arvalid & ~bus.s_axi_rvalid;
  assign bus.s_axi_awready = wr_go;
  assign bus.s_axi_wready  = wr_go;
  assign bus.s_axi_arready = rd_go;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign tx_vac   = TX_FULL_CNT - tx_count;

  assign flush   = wr_go & (wr_sel == REG_CTRL) & (bus.s_axi_wdata[7:0] == 8'hA5);
  assign wr_txd  = wr_go & ((wr_sel == REG_TXD) | (wr_sel == REG_TXD_LAST));
  // fullness is judged on the registered count, so a same-cycle stream pop does not rescue a CPU write
  assign tx_push = wr_txd & ~tx_full;
  assign tx_err  = wr_txd & tx_full;
  assign tx_pop  = ~tx_empty & bus.axi_str_txd_tready;

  assign rd_rxd  = rd_go & (rd_sel == REG_RXD);
  assign rx_pop  = rd_rxd & ~rx_empty;
  assign rx_err  = rd_rxd & rx_empty;
  // a CPU pop in this cycle frees a slot, so a full RX still accepts a word alongside it
  assign bus.axi_str_rxd_tready = run & (~rx_full | rx_pop);
  assign rx_push = bus.axi_str_rxd_tvalid & bus.axi_str_rxd_tready;

  assign bus.axi_str_txd_tvalid = ~tx_empty;
  assign bus.axi_str_txd_tlast  = tx_mem[tx_rd_ptr][32];
  assign bus.axi_str_txd_tdata  = tx_mem[tx_rd_ptr][31:0];

  always_ff @(posedge s_axi_aclk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {(wr_sel == REG_TXD_LAST), bus.s_axi_wdata};
    if (rx_push) rx_mem[rx_wr_ptr] <= {bus.axi_str_rxd_tlast, bus.axi_str_rxd_tdata};
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      run       <= 1'b0;
      flush_n   <= 1'b0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      run     <= 1'b1;
      flush_n <= ~flush;
      if (flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_count  <= '0;
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_count  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
        else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
        else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
      end
    end
  end

  assign mm2s_prmry_reset_out_n = flush_n;
  assign s2mm_prmry_reset_out_n = flush_n;

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      REG_RXD:     if (!rx_empty) rd_mux = rx_mem[rx_rd_ptr][31:0];
      REG_STATUS:  rd_mux = {16'(rx_count), 16'(tx_vac)};
      REG_RX_HEAD: rd_mux = {30'd0, rx_mem[rx_rd_ptr][32] & ~rx_empty, ~rx_empty};
      REG_ISR:     rd_mux = {29'd0, isr};
      REG_IER:     rd_mux = {29'd0, ier};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      bus.s_axi_bvalid <= 1'b0;
      bus.s_axi_bresp  <= '0;
      bus.s_axi_rvalid <= 1'b0;
      bus.s_axi_rresp  <= '0;
      bus.s_axi_rdata  <= '0;
    end else begin
      if (wr_go) begin
        bus.s_axi_bvalid <= 1'b1;
        bus.s_axi_bresp  <= tx_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bus.s_axi_bready) begin
        bus.s_axi_bvalid <= 1'b0;
      end
      if (rd_go) begin
        bus.s_axi_rvalid <= 1'b1;
        bus.s_axi_rresp  <= rx_err ? RESP_SLVERR : RESP_OKAY;
        bus.s_axi_rdata  <= rd_mux;
      end else if (bus.s_axi_rready) begin
        bus.s_axi_rvalid <= 1'b0;
      end
    end
  end

  // flush suppresses occupancy events: its own TX emptying must not look like a drain
  assign irq_ev = {tx_err | rx_err,
                   (tx_count == (TXA+1)'(1)) & tx_pop & ~tx_push & ~flush,
                   rx_empty & rx_push & ~flush};

`ifdef AXIL_FIFO_IRQ_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      isr <= '0;
      ier <= '0;
    end else begin
      if (wr_go && wr_sel == REG_ISR) isr <= (isr & ~bus.s_axi_wdata[2:0]) | irq_ev;
      else                            isr <= isr | irq_ev;
      if (wr_go && wr_sel == REG_IER) ier <= bus.s_axi_wdata[2:0];
    end
  end
  assign interrupt = |(isr & ier);
`else
  logic unused_irq;
  assign isr        = '0;
  assign ier        = '0;
  assign interrupt  = 1'b0;
  assign unused_irq = ^irq_ev;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.s_axi_awaddr[ADDR_W-1:5], bus.s_axi_awaddr[1:0],
                         bus.s_axi_araddr[ADDR_W-1:5], bus.s_axi_araddr[1:0],
                         bus.s_axi_wstrb};
endmodule

// File: tb/tb_axil_stream_fifo.sv
module tb_axil_stream_fifo;
`ifdef AXIL_FIFO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [31:0] A_TXD = 32'h00, A_TXDL = 32'h04, A_RXD = 32'h08, A_STAT = 32'h0C;
  localparam logic [31:0] A_HEAD = 32'h10, A_ISR = 32'h14, A_IER = 32'h18, A_CTRL = 32'h1C;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic mm2s_n, s2mm_n, irq;
  int checks = 0;
  int failures = 0;
  logic [32:0] txq[$];
  logic snap_tvalid, snap_mm2s, snap_s2mm;

  always #5 clk = ~clk;

  axil_stream_fifo_if #(.ADDR_W(32)) bus ();

  axil_stream_fifo #(.TX_DEPTH(512), .RX_DEPTH(512), .ADDR_W(32)) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(aresetn),
    .bus(bus),
    .mm2s_prmry_reset_out_n(mm2s_n),
    .s2mm_prmry_reset_out_n(s2mm_n),
    .interrupt(irq)
  );

  always @(negedge clk)
    if (aresetn && bus.axi_str_txd_tvalid && bus.axi_str_txd_tready)
      txq.push_back({bus.axi_str_txd_tlast, bus.axi_str_txd_tdata});

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // all bus tasks start and end at posedge+1
  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    logic hs, done;
    hs = 1'b0; done = 1'b0; resp = 2'b11;
    bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = bus.s_axi_awready & bus.s_axi_wready;
      @(posedge clk); #1;
    end
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    snap_tvalid = bus.axi_str_txd_tvalid; snap_mm2s = mm2s_n; snap_s2mm = s2mm_n;
    if (!hs) chk("wr_handshake", {31'd0, hs}, 32'd1);
    bus.s_axi_bready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1; if (bus.s_axi_bvalid) begin resp = bus.s_axi_bresp; done = 1'b1; end
      @(posedge clk); #1;
    end
    bus.s_axi_bready = 1'b0;
    if (!done) chk("wr_response", {31'd0, done}, 32'd1);
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic hs, done;
    hs = 1'b0; done = 1'b0; resp = 2'b11; data = 32'hxxxx_xxxx;
    bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = bus.s_axi_arready;
      @(posedge clk); #1;
    end
    bus.s_axi_arvalid = 1'b0;
    if (!hs) chk("rd_handshake", {31'd0, hs}, 32'd1);
    bus.s_axi_rready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      #1; if (bus.s_axi_rvalid) begin data = bus.s_axi_rdata; resp = bus.s_axi_rresp; done = 1'b1; end
      @(posedge clk); #1;
    end
    bus.s_axi_rready = 1'b0;
    if (!done) chk("rd_response", {31'd0, done}, 32'd1);
  endtask

  task automatic rx_send(input logic [31:0] d, input logic l);
    logic hs;
    hs = 1'b0;
    bus.axi_str_rxd_tvalid = 1'b1; bus.axi_str_rxd_tdata = d; bus.axi_str_rxd_tlast = l;
    for (int n = 0; n < 20 && !hs; n++) begin
      #1; hs = bus.axi_str_rxd_tready;
      @(posedge clk); #1;
    end
    bus.axi_str_rxd_tvalid = 1'b0;
    if (!hs) chk("rx_push_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0] r;
    axi_rd(addr, d, r);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_resp"}, {30'd0, r}, {30'd0, exp_r});
  endtask

  initial begin
    logic [1:0] r;
    logic [31:0] exp_rx_words [3];
    int bad;
    logic seen_b;

    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0; bus.s_axi_araddr = '0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    bus.axi_str_txd_tready = 1'b0; bus.axi_str_rxd_tvalid = 1'b0;
    bus.axi_str_rxd_tlast = 1'b0; bus.axi_str_rxd_tdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", {31'd0, bus.s_axi_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
    chk("rst_tvalid", {31'd0, bus.axi_str_txd_tvalid}, 32'd0);
    chk("rst_rx_tready", {31'd0, bus.axi_str_rxd_tready}, 32'd0);
    chk("rst_reset_out", {30'd0, mm2s_n, s2mm_n}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rx_tready", {31'd0, bus.axi_str_rxd_tready}, 32'd1);
    chk("post_rst_reset_out", {30'd0, mm2s_n, s2mm_n}, 32'd3);
    rd_chk("status_reset", A_STAT, 32'h0000_0200, 2'b00);

    // TX stream with tlast only on the TXD_LAST word
    bus.axi_str_txd_tready = 1'b1;
    axi_wr(A_TXD, 32'h11, r);
    axi_wr(A_TXD, 32'h22, r);
    axi_wr(A_TXDL, 32'h33, r);
    chk("txd_last_bresp", {30'd0, r}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("tx_count", txq.size(), 32'd3);
    if (txq.size() == 3) begin
      chk("tx0", {31'd0, txq[0][32]} << 8 | txq[0][7:0], 32'h011);
      chk("tx1", {31'd0, txq[1][32]} << 8 | txq[1][7:0], 32'h022);
      chk("tx2", {31'd0, txq[2][32]} << 8 | txq[2][7:0], 32'h133);
    end
    rd_chk("status_tx_drained", A_STAT, 32'h0000_0200, 2'b00);
    rd_chk("isr_tx_empty", A_ISR, IRQ ? 32'h2 : 32'h0, 2'b00);
    axi_wr(A_ISR, 32'h2, r);
    rd_chk("isr_cleared1", A_ISR, 32'h0, 2'b00);

    // RX words, head status and empty-read error
    exp_rx_words[0] = 32'hA1; exp_rx_words[1] = 32'hA2; exp_rx_words[2] = 32'hA3;
    rx_send(32'hA1, 1'b0);
    rx_send(32'hA2, 1'b0);
    rx_send(32'hA3, 1'b1);
    rd_chk("rx_head0", A_HEAD, 32'h1, 2'b00);
    rd_chk("rxd0", A_RXD, exp_rx_words[0], 2'b00);
    rd_chk("rx_head1", A_HEAD, 32'h1, 2'b00);
    rd_chk("rxd1", A_RXD, exp_rx_words[1], 2'b00);
    rd_chk("rx_head2", A_HEAD, 32'h3, 2'b00);
    rd_chk("rxd2", A_RXD, exp_rx_words[2], 2'b00);
    rd_chk("rxd_empty", A_RXD, 32'h0, 2'b10);
    rd_chk("rx_head_empty", A_HEAD, 32'h0, 2'b00);
    rd_chk("isr_rx", A_ISR, IRQ ? 32'h5 : 32'h0, 2'b00);
    axi_wr(A_ISR, 32'h7, r);
    rd_chk("isr_cleared2", A_ISR, 32'h0, 2'b00);

    // TX overflow
    bus.axi_str_txd_tready = 1'b0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      axi_wr(A_TXD, i, r);
      if (r != 2'b00) bad++;
    end
    chk("tx_fill_okay", bad, 32'd0);
    axi_wr(A_TXD, 32'hBAD, r);
    chk("tx_overflow_bresp", {30'd0, r}, 32'd2);
    rd_chk("status_tx_full", A_STAT, 32'h0000_0000, 2'b00);
    rd_chk("isr_err", A_ISR, IRQ ? 32'h4 : 32'h0, 2'b00);
    axi_wr(A_IER, 32'h4, r);
    chk("irq_err", {31'd0, irq}, {31'd0, IRQ});
    axi_wr(A_ISR, 32'h4, r);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("isr_cleared3", A_ISR, 32'h0, 2'b00);

    txq.delete();
    bus.axi_str_txd_tready = 1'b1;
    for (int n = 0; n < 3000 && bus.axi_str_txd_tvalid; n++) begin
      @(posedge clk); #1;
    end
    chk("tx_drain_done", {31'd0, bus.axi_str_txd_tvalid}, 32'd0);
    chk("tx_drain_count", txq.size(), 32'd512);
    if (txq.size() == 512) begin
      chk("tx_drain_first", txq[0][31:0], 32'd0);
      chk("tx_drain_last", {txq[511][32], txq[511][30:0]}, 32'd511);
    end

    // RX full: push and pop in the same cycle
    for (int i = 0; i < 512; i++) rx_send(32'h1000 + i, 1'b0);
    chk("rx_full_tready", {31'd0, bus.axi_str_rxd_tready}, 32'd0);
    bus.axi_str_rxd_tvalid = 1'b1; bus.axi_str_rxd_tdata = 32'hDEAD_BEEF; bus.axi_str_rxd_tlast = 1'b1;
    rd_chk("rxd_full_pop", A_RXD, 32'h0000_1000, 2'b00);
    bus.axi_str_rxd_tvalid = 1'b0;
    rd_chk("status_rx_full", A_STAT, 32'h0200_0200, 2'b00);
    rd_chk("rxd_after_full", A_RXD, 32'h0000_1001, 2'b00);

    // flush with 5 words in TX
    bus.axi_str_txd_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      axi_wr(A_TXD, 32'h50 + i, r);
      if (i == 0) chk("tx_latency_tvalid", {31'd0, snap_tvalid}, 32'd1);
    end
    axi_wr(A_CTRL, 32'hA5, r);
    chk("flush_reset_out", {30'd0, snap_mm2s, snap_s2mm}, 32'd0);
    chk("flush_tvalid", {31'd0, snap_tvalid}, 32'd0);
    chk("flush_reset_out_after", {30'd0, mm2s_n, s2mm_n}, 32'd3);
    rd_chk("status_flushed", A_STAT, 32'h0000_0200, 2'b00);
    rd_chk("isr_after_flush", A_ISR, IRQ ? 32'h3 : 32'h0, 2'b00);
    rd_chk("ier_after_flush", A_IER, IRQ ? 32'h4 : 32'h0, 2'b00);
    chk("flush_no_tx_out", txq.size(), 32'd512);

    // reset while a write response is pending
    bus.s_axi_awaddr = A_TXD; bus.s_axi_wdata = 32'h77;
    bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_bready = 1'b0;
    seen_b = 1'b0;
    for (int n = 0; n < 20 && !seen_b; n++) begin
      #1; seen_b = bus.s_axi_awready;
      @(posedge clk); #1;
    end
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    chk("pending_bvalid", {31'd0, bus.s_axi_bvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    chk("async_bvalid_drop", {31'd0, bus.s_axi_bvalid}, 32'd0);
    chk("async_tvalid_drop", {31'd0, bus.axi_str_txd_tvalid}, 32'd0);
    chk("async_reset_out", {30'd0, mm2s_n, s2mm_n}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    bus.s_axi_bready = 1'b1;
    seen_b = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (bus.s_axi_bvalid) seen_b = 1'b1;
    end
    bus.s_axi_bready = 1'b0;
    chk("no_b_after_reset", {31'd0, seen_b}, 32'd0);
    rd_chk("status_after_reset", A_STAT, 32'h0000_0200, 2'b00);
    rd_chk("isr_after_reset", A_ISR, 32'h0, 2'b00);
    rd_chk("ier_after_reset", A_IER, 32'h0, 2'b00);
    rd_chk("ctrl_read_zero", A_CTRL, 32'h0, 2'b00);
    rd_chk("txd_read_zero", A_TXD, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
